axi4lite_arbiter: RTL and testbench

AXI4LITE_ARBITER -- requirements
Module: axi4lite_arbiter

---
 rtl/axi4lite_arb_pkg.sv | 35 +++
 rtl/axi4lite_rr_pick.sv | 40 ++++
 rtl/axi4lite_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_axi4lite_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_arb_pkg.sv
// ============================================================================
// Module      : axi4lite_arb_pkg
// Description : Shared types and constants for the AXI4-Lite requester
//               arbiter: FSM state encoding, AXI response codes and a
//               helper that sizes requester index fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4lite_arb_pkg;

   // One transaction in flight: the state names the channel being served.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W_AW = 3'd1,
      W_W  = 3'd2,
      W_B  = 3'd3,
      R_AR = 3'd4,
      R_R  = 3'd5
   } arb_state_t;

   // AXI response codes, passed through untouched from slave to requester.
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Width of a requester index; never narrower than one bit.
   function automatic int arb_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi4lite_rr_pick.sv
// ============================================================================
// Module      : axi4lite_rr_pick
// Description : Combinational pointer-based one-hot picker. The winner is the
//               first requesting index strictly after i_ptr, wrapping modulo
//               NUM_REQ. Tying i_ptr to NUM_REQ-1 yields lowest-index-wins
//               fixed priority, so the same block serves both modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_any,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx
);

   // Scan distances 1..NUM_REQ from the pointer; the nearest requester wins.
   always_comb begin
      o_any = 1'b0;
      o_gnt = '0;
      o_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (((int'(i_ptr) + k) % NUM_REQ) == j)) begin
               o_any    = 1'b1;
               o_gnt[j] = 1'b1;
               o_idx    = IDX_W'(j);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi4lite_arbiter.sv
// ============================================================================
// Module      : axi4lite_arbiter
// Description : Arbitrates NUM_REQ AXI4-Lite requesters onto one AXI4-Lite
//               master port, one transaction at a time. Writes take
//               precedence over reads from the same requester. Channels of
//               the granted requester are wired straight through to the
//               master port for the state currently being served.
//               Build option: AXI4LITE_ARB_RR_EN selects round-robin
//               arbitration; when undefined, fixed priority (index 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_arbiter
   import axi4lite_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   // requester write-address channels
   input  logic [NUM_REQ-1:0]            s_aw_valid,
   output logic [NUM_REQ-1:0]            s_aw_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     s_aw_addr,
   input  logic [NUM_REQ*3-1:0]          s_aw_prot,
   // requester write-data channels
   input  logic [NUM_REQ-1:0]            s_w_valid,
   output logic [NUM_REQ-1:0]            s_w_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     s_w_data,
   input  logic [NUM_REQ*(DATA_W/8)-1:0] s_w_strb,
   // requester write-response channels
   output logic [NUM_REQ-1:0]            s_b_valid,
   input  logic [NUM_REQ-1:0]            s_b_ready,
   output logic [NUM_REQ*2-1:0]          s_b_resp,
   // requester read-address channels
   input  logic [NUM_REQ-1:0]            s_ar_valid,
   output logic [NUM_REQ-1:0]            s_ar_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     s_ar_addr,
   input  logic [NUM_REQ*3-1:0]          s_ar_prot,
   // requester read-data channels
   output logic [NUM_REQ-1:0]            s_r_valid,
   input  logic [NUM_REQ-1:0]            s_r_ready,
   output logic [NUM_REQ*DATA_W-1:0]     s_r_data,
   output logic [NUM_REQ*2-1:0]          s_r_resp,
   // master port to the shared slave
   output logic                          m_aw_valid,
   input  logic                          m_aw_ready,
   output logic [ADDR_W-1:0]             m_aw_addr,
   output logic [2:0]                    m_aw_prot,
   output logic                          m_w_valid,
   input  logic                          m_w_ready,
   output logic [DATA_W-1:0]             m_w_data,
   output logic [DATA_W/8-1:0]           m_w_strb,
   input  logic                          m_b_valid,
   output logic                          m_b_ready,
   input  logic [1:0]                    m_b_resp,
   output logic                          m_ar_valid,
   input  logic                          m_ar_ready,
   output logic [ADDR_W-1:0]             m_ar_addr,
   output logic [2:0]                    m_ar_prot,
   input  logic                          m_r_valid,
   output logic                          m_r_ready,
   input  logic [DATA_W-1:0]             m_r_data,
   input  logic [1:0]                    m_r_resp
);

   localparam int IDX_W  = arb_idx_w(NUM_REQ);
   localparam int STRB_W = DATA_W / 8;

   arb_state_t         r_state;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   w_ptr;

   logic [NUM_REQ-1:0] w_req;
   logic               w_pick_any;
   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_wr;

   // Granted requester's signals, selected by r_grant.
   logic [NUM_REQ-1:0] w_g_onehot;
   logic               w_g_aw_valid;
   logic [ADDR_W-1:0]  w_g_aw_addr;
   logic [2:0]         w_g_aw_prot;
   logic               w_g_w_valid;
   logic [DATA_W-1:0]  w_g_w_data;
   logic [STRB_W-1:0]  w_g_w_strb;
   logic               w_g_b_ready;
   logic               w_g_ar_valid;
   logic [ADDR_W-1:0]  w_g_ar_addr;
   logic [2:0]         w_g_ar_prot;
   logic               w_g_r_ready;

   logic               w_aw_hs;
   logic               w_w_hs;
   logic               w_b_hs;
   logic               w_ar_hs;
   logic               w_r_hs;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   assign w_req = s_aw_valid | s_ar_valid;

   axi4lite_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req   (w_req),
      .i_ptr   (w_ptr),
      .o_any   (w_pick_any),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx)
   );

   // A winner that has a write pending is served write first.
   assign w_pick_wr = |(w_pick_gnt & s_aw_valid);

`ifdef AXI4LITE_ARB_RR_EN
   logic [IDX_W-1:0] r_ptr;

   // Pointer advances to the served requester only when its transaction ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= IDX_W'(NUM_REQ - 1);
      end else if (w_b_hs || w_r_hs) begin
         r_ptr <= r_grant;
      end
   end

   assign w_ptr = r_ptr;
`else
   // Pointer pinned just below index 0, so the picker favours the lowest index.
   assign w_ptr = IDX_W'(NUM_REQ - 1);
`endif

   // -------------------------------------------------------------------------
   // Transaction FSM
   // -------------------------------------------------------------------------
   // Grant in IDLE, then walk the channels of the single in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_grant <= w_pick_idx;
                  r_state <= w_pick_wr ? W_AW : R_AR;
               end
            end
            W_AW:    if (w_aw_hs) r_state <= W_W;
            W_W:     if (w_w_hs)  r_state <= W_B;
            W_B:     if (w_b_hs)  r_state <= IDLE;
            R_AR:    if (w_ar_hs) r_state <= R_R;
            R_R:     if (w_r_hs)  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Datapath routing
   // -------------------------------------------------------------------------
   // Select the granted requester's channels with constant-index slices.
   always_comb begin
      w_g_onehot   = '0;
      w_g_aw_valid = 1'b0;
      w_g_aw_addr  = '0;
      w_g_aw_prot  = '0;
      w_g_w_valid  = 1'b0;
      w_g_w_data   = '0;
      w_g_w_strb   = '0;
      w_g_b_ready  = 1'b0;
      w_g_ar_valid = 1'b0;
      w_g_ar_addr  = '0;
      w_g_ar_prot  = '0;
      w_g_r_ready  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant == IDX_W'(i)) begin
            w_g_onehot[i] = 1'b1;
            w_g_aw_valid  = s_aw_valid[i];
            w_g_aw_addr   = s_aw_addr[i*ADDR_W +: ADDR_W];
            w_g_aw_prot   = s_aw_prot[i*3 +: 3];
            w_g_w_valid   = s_w_valid[i];
            w_g_w_data    = s_w_data[i*DATA_W +: DATA_W];
            w_g_w_strb    = s_w_strb[i*STRB_W +: STRB_W];
            w_g_b_ready   = s_b_ready[i];
            w_g_ar_valid  = s_ar_valid[i];
            w_g_ar_addr   = s_ar_addr[i*ADDR_W +: ADDR_W];
            w_g_ar_prot   = s_ar_prot[i*3 +: 3];
            w_g_r_ready   = s_r_ready[i];
         end
      end
   end

   // Forward valids only for the channel the FSM is currently serving.
   assign m_aw_valid = (r_state == W_AW) && w_g_aw_valid;
   assign m_aw_addr  = w_g_aw_addr;
   assign m_aw_prot  = w_g_aw_prot;
   assign m_w_valid  = (r_state == W_W) && w_g_w_valid;
   assign m_w_data   = w_g_w_data;
   assign m_w_strb   = w_g_w_strb;
   assign m_b_ready  = (r_state == W_B) && w_g_b_ready;
   assign m_ar_valid = (r_state == R_AR) && w_g_ar_valid;
   assign m_ar_addr  = w_g_ar_addr;
   assign m_ar_prot  = w_g_ar_prot;
   assign m_r_ready  = (r_state == R_R) && w_g_r_ready;

   // Readies/valids back to requesters go only to the granted index.
   assign s_aw_ready = ((r_state == W_AW) && m_aw_ready) ? w_g_onehot : '0;
   assign s_w_ready  = ((r_state == W_W)  && m_w_ready)  ? w_g_onehot : '0;
   assign s_b_valid  = ((r_state == W_B)  && m_b_valid)  ? w_g_onehot : '0;
   assign s_ar_ready = ((r_state == R_AR) && m_ar_ready) ? w_g_onehot : '0;
   assign s_r_valid  = ((r_state == R_R)  && m_r_valid)  ? w_g_onehot : '0;

   // Response payloads are broadcast; the per-requester valid qualifies them.
   assign s_b_resp = {NUM_REQ{m_b_resp}};
   assign s_r_resp = {NUM_REQ{m_r_resp}};
   assign s_r_data = {NUM_REQ{m_r_data}};

   assign w_aw_hs = m_aw_valid && m_aw_ready;
   assign w_w_hs  = m_w_valid  && m_w_ready;
   assign w_b_hs  = m_b_valid  && m_b_ready;
   assign w_ar_hs = m_ar_valid && m_ar_ready;
   assign w_r_hs  = m_r_valid  && m_r_ready;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_arbiter.sv
// ============================================================================
// Module      : tb_axi4lite_arbiter
// Description : Directed self-checking bench for axi4lite_arbiter with two
//               requesters. Expected grant order depends on
//               AXI4LITE_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4lite_arbiter;
   import axi4lite_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
   logic [N-1:0]    s_b_valid, s_b_ready, s_ar_valid, s_ar_ready;
   logic [N-1:0]    s_r_valid, s_r_ready;
   logic [N*AW-1:0] s_aw_addr, s_ar_addr;
   logic [N*3-1:0]  s_aw_prot, s_ar_prot;
   logic [N*DW-1:0] s_w_data, s_r_data;
   logic [N*SW-1:0] s_w_strb;
   logic [N*2-1:0]  s_b_resp, s_r_resp;
   logic            m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
   logic            m_b_valid, m_b_ready, m_ar_valid, m_ar_ready;
   logic            m_r_valid, m_r_ready;
   logic [AW-1:0]   m_aw_addr, m_ar_addr;
   logic [2:0]      m_aw_prot, m_ar_prot;
   logic [DW-1:0]   m_w_data, m_r_data;
   logic [SW-1:0]   m_w_strb;
   logic [1:0]      m_b_resp, m_r_resp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi4lite_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
      .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp)
   );

   function automatic logic any_active();
      return |{s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid,
               m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready};
   endfunction

   task automatic clear_inputs();
      s_aw_valid = '0; s_aw_addr = '0; s_aw_prot = '0;
      s_w_valid  = '0; s_w_data  = '0; s_w_strb  = '0;
      s_b_ready  = '0;
      s_ar_valid = '0; s_ar_addr = '0; s_ar_prot = '0;
      s_r_ready  = '0;
      m_aw_ready = 1'b0; m_w_ready = 1'b0;
      m_b_valid  = 1'b0; m_b_resp  = '0;
      m_ar_ready = 1'b0;
      m_r_valid  = 1'b0; m_r_data  = '0; m_r_resp = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      s_aw_valid = 2'b11; s_ar_valid = 2'b11; s_w_valid = 2'b11;
      s_b_ready = 2'b11; s_r_ready = 2'b11;
      m_aw_ready = 1'b1; m_w_ready = 1'b1; m_b_valid = 1'b1;
      m_ar_ready = 1'b1; m_r_valid = 1'b1;
      @(negedge clk); #1;
      total++;
      if (any_active() !== 1'b0) begin
         bad++; $display("FAIL reset_outputs: got %b want 0", any_active());
      end
      clear_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (any_active() !== 1'b0) begin
         bad++; $display("FAIL idle_no_req: got %b want 0", any_active());
      end
   endtask

   task automatic test_write();
      do_reset();
      s_aw_addr[31:0] = 32'h1000; s_aw_prot[2:0] = 3'b010; s_aw_valid = 2'b01;
      s_w_data[63:0] = 64'hA5A5; s_w_strb[7:0] = 8'hFF; s_w_valid = 2'b01;
      s_b_ready = 2'b11; m_aw_ready = 1'b1; m_w_ready = 1'b1;
      #1;
      total++;
      if (m_aw_valid !== 1'b0) begin
         bad++; $display("FAIL aw_in_idle: got %b want 0", m_aw_valid);
      end
      @(negedge clk); #1;
      total++;
      if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h1000 || m_aw_prot !== 3'b010) begin
         bad++; $display("FAIL aw_latency: got v=%b a=%h p=%b want v=1 a=00001000 p=010",
                         m_aw_valid, m_aw_addr, m_aw_prot);
      end
      total++;
      if (s_aw_ready !== 2'b01) begin
         bad++; $display("FAIL aw_ready_route: got %b want 01", s_aw_ready);
      end
      @(negedge clk);
      s_aw_valid = 2'b00;
      #1;
      total++;
      if (m_w_valid !== 1'b1 || m_w_data !== 64'hA5A5 || m_w_strb !== 8'hFF ||
          s_w_ready !== 2'b01 || m_aw_valid !== 1'b0) begin
         bad++; $display("FAIL w_phase: got v=%b d=%h s=%h rdy=%b aw=%b want v=1 d=a5a5 s=ff rdy=01 aw=0",
                         m_w_valid, m_w_data, m_w_strb, s_w_ready, m_aw_valid);
      end
      @(negedge clk);
      s_w_valid = 2'b00; m_b_valid = 1'b1; m_b_resp = OKAY;
      #1;
      total++;
      if (s_b_valid !== 2'b01 || s_b_resp[1:0] !== 2'b00 || m_b_ready !== 1'b1) begin
         bad++; $display("FAIL b_okay: got bv=%b resp=%b mbr=%b want bv=01 resp=00 mbr=1",
                         s_b_valid, s_b_resp[1:0], m_b_ready);
      end
      @(negedge clk);
      m_b_valid = 1'b0;
      #1;
      total++;
      if (any_active() !== 1'b0) begin
         bad++; $display("FAIL write_done_idle: got %b want 0", any_active());
      end
   endtask

   task automatic test_arbitration();
      logic [N-1:0] oh;
      int           exp;
      int           c;
      do_reset();
      s_ar_addr = {32'h0000_0200, 32'h0000_0100};
      s_ar_valid = 2'b11; s_r_ready = 2'b11; m_ar_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef AXI4LITE_ARB_RR_EN
         exp = k % 2;
`else
         exp = 0;
`endif
         oh = (exp == 1) ? 2'b10 : 2'b01;
         c = 0;
         while (m_ar_valid !== 1'b1 && c < 8) begin
            @(negedge clk); #1;
            c++;
         end
         total++;
         if (m_ar_valid !== 1'b1) begin
            bad++; $display("FAIL ar_timeout read%0d: got m_ar_valid=%b want 1", k, m_ar_valid);
         end else if (m_ar_addr !== ((exp == 1) ? 32'h200 : 32'h100) || s_ar_ready !== oh) begin
            bad++; $display("FAIL grant_order read%0d: got addr=%h rdy=%b want requester %0d",
                            k, m_ar_addr, s_ar_ready, exp);
         end
         @(negedge clk);
         m_r_valid = 1'b1; m_r_data = 64'(k + 16); m_r_resp = OKAY;
         #1;
         total++;
         if (s_r_valid !== oh || s_r_data[exp*DW +: DW] !== 64'(k + 16)) begin
            bad++; $display("FAIL r_route read%0d: got rv=%b d=%h want rv=%b d=%h",
                            k, s_r_valid, s_r_data[exp*DW +: DW], oh, 64'(k + 16));
         end
         @(negedge clk);
         m_r_valid = 1'b0;
         #1;
      end
   endtask

   task automatic test_write_first();
      do_reset();
      s_aw_addr[63:32] = 32'h2000; s_ar_addr[63:32] = 32'h3000;
      s_aw_valid = 2'b10; s_ar_valid = 2'b10; s_w_valid = 2'b10;
      s_w_data[127:64] = 64'h1234; s_w_strb[15:8] = 8'h0F;
      s_b_ready = 2'b10; s_r_ready = 2'b10;
      m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
      @(negedge clk); #1;
      total++;
      if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h2000 || m_ar_valid !== 1'b0 ||
          s_ar_ready !== 2'b00 || s_aw_ready !== 2'b10) begin
         bad++; $display("FAIL write_first: got aw=%b a=%h ar=%b arr=%b awr=%b want aw=1 a=00002000 ar=0 arr=00 awr=10",
                         m_aw_valid, m_aw_addr, m_ar_valid, s_ar_ready, s_aw_ready);
      end
      @(negedge clk);
      s_aw_valid = 2'b00;
      #1;
      total++;
      if (m_w_valid !== 1'b1 || m_w_data !== 64'h1234 || m_w_strb !== 8'h0F ||
          s_w_ready !== 2'b10 || m_ar_valid !== 1'b0) begin
         bad++; $display("FAIL w_req1: got v=%b d=%h s=%h rdy=%b ar=%b want v=1 d=1234 s=0f rdy=10 ar=0",
                         m_w_valid, m_w_data, m_w_strb, s_w_ready, m_ar_valid);
      end
      @(negedge clk);
      s_w_valid = 2'b00; m_b_valid = 1'b1; m_b_resp = DECERR;
      #1;
      total++;
      if (s_b_valid !== 2'b10 || s_b_resp[3:2] !== 2'b11) begin
         bad++; $display("FAIL b_decerr: got bv=%b resp=%b want bv=10 resp=11", s_b_valid, s_b_resp[3:2]);
      end
      @(negedge clk);
      m_b_valid = 1'b0;
      #1;
      total++;
      if (m_ar_valid !== 1'b0) begin
         bad++; $display("FAIL idle_gap: got m_ar_valid=%b want 0", m_ar_valid);
      end
      @(negedge clk); #1;
      total++;
      if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h3000 || s_ar_ready !== 2'b10) begin
         bad++; $display("FAIL read_after_write: got v=%b a=%h rdy=%b want v=1 a=00003000 rdy=10",
                         m_ar_valid, m_ar_addr, s_ar_ready);
      end
      @(negedge clk);
      s_ar_valid = 2'b00; m_r_valid = 1'b1; m_r_resp = SLVERR; m_r_data = 64'hDEAD;
      #1;
      total++;
      if (s_r_valid !== 2'b10 || s_r_resp[3:2] !== 2'b10 || s_r_data[127:64] !== 64'hDEAD ||
          m_r_ready !== 1'b1) begin
         bad++; $display("FAIL r_slverr: got rv=%b resp=%b d=%h mrr=%b want rv=10 resp=10 d=dead mrr=1",
                         s_r_valid, s_r_resp[3:2], s_r_data[127:64], m_r_ready);
      end
      @(negedge clk);
      m_r_valid = 1'b0;
      #1;
      total++;
      if (any_active() !== 1'b0) begin
         bad++; $display("FAIL read_done_idle: got %b want 0", any_active());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      s_aw_addr = {32'h0000_5000, 32'h0000_4000};
      s_aw_valid = 2'b01; s_w_valid = 2'b01; s_w_data[63:0] = 64'h77;
      s_b_ready = 2'b11; m_aw_ready = 1'b1; m_w_ready = 1'b0;
      @(negedge clk); #1;
      total++;
      if (m_aw_valid !== 1'b1) begin
         bad++; $display("FAIL mid_aw: got %b want 1", m_aw_valid);
      end
      @(negedge clk); #1;
      total++;
      if (m_w_valid !== 1'b1) begin
         bad++; $display("FAIL mid_in_w: got %b want 1", m_w_valid);
      end
      rst = 1'b1;
      s_aw_valid = 2'b11; m_w_ready = 1'b1; m_b_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (any_active() !== 1'b0) begin
         bad++; $display("FAIL reset_mid_clears: got %b want 0", any_active());
      end
      @(negedge clk); #1;
      total++;
      if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h4000 || s_aw_ready !== 2'b01 || s_b_valid !== 2'b00) begin
         bad++; $display("FAIL fresh_req0_first: got v=%b a=%h rdy=%b bv=%b want v=1 a=00004000 rdy=01 bv=00",
                         m_aw_valid, m_aw_addr, s_aw_ready, s_b_valid);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_write();
      test_arbitration();
      test_write_first();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
